serial_addsub: RTL and testbench

Multi-cycle, parametrised adder/subtractor. It generalises the single-bit full adder to a WIDTH-bit operation processed CHUNK bits per clock. A registered carry chains the chunks together. Operands are captured on a Start handshake, and a one-cycle Done pulse marks a stable result. It sits in the datapath wherever a narrow, area-cheap adder with add/subtract mode is needed.

---
 rtl/serial_addsub.sv | 155 +++++++++++++++
 tb/tb_serial_addsub.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   Start            request, accepted only in IDLE
//   Sub              0 = A+B+Cin, 1 = A-B-Cin (Cin acts as borrow-in)
//   A, B, Cin        operands, sampled only when Start is accepted
//   Busy             high in RUN and DONE
//   Done             one-cycle pulse, Sum/Cout/Ovf valid
//   Sum, Cout, Ovf   registered result, carry out of MSB (1 = no borrow when
//                    subtracting), signed overflow
//
// WIDTH must be a multiple of CHUNK. CHUNK == WIDTH is legal.

// One chunk of the ripple: CHUNK-bit add with carry in/out.
module serial_addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
endmodule

module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] beff_q, beff_d;   // B, or ~B when subtracting
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] work_q, work_d;   // partial result, never exposed on Sum
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             c_chunk;
  logic [WIDTH-1:0] res;
  logic             last_chunk;

  always_comb begin
    a_chunk = a_q[int'(idx_q)*CHUNK +: CHUNK];
    b_chunk = beff_q[int'(idx_q)*CHUNK +: CHUNK];
  end

  serial_addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_chunk),
    .b  (b_chunk),
    .ci (carry_q),
    .s  (s_chunk),
    .co (c_chunk)
  );

  // Working sum with the current chunk merged in; on the last chunk this is
  // the complete result.
  always_comb begin
    res = work_q;
    res[int'(idx_q)*CHUNK +: CHUNK] = s_chunk;
  end

  assign last_chunk = (idx_q == IW'(NCHUNK - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    beff_d  = beff_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          // Subtract as A + ~B + ~Cin: borrow-in inverts to carry-in.
          a_d     = A;
          beff_d  = Sub ? ~B : B;
          carry_d = Sub ? ~Cin : Cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d  = res;
        carry_d = c_chunk;
        idx_d   = idx_q + 1'b1;
        if (last_chunk) begin
          idx_d   = '0;
          state_d = DONE;
          sum_d   = res;
          cout_d  = c_chunk;
          ovf_d   = (a_q[WIDTH-1] == beff_q[WIDTH-1]) &&
                    (res[WIDTH-1] != a_q[WIDTH-1]);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      beff_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      beff_q  <= beff_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start = 1'b0, Sub = 1'b0, Cin = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        Busy, Done, Cout, Ovf;
  logic [15:0] Sum;

  // degenerate WIDTH = CHUNK = 1 instance
  logic        s_start = 1'b0, s_sub = 1'b0, s_cin = 1'b0;
  logic [0:0]  s_a = '0, s_b = '0;
  logic        s_busy, s_done, s_cout, s_ovf;
  logic [0:0]  s_sum;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_addsub dut (
    .clk(clk), .rst(rst), .Start(Start), .Sub(Sub), .A(A), .B(B), .Cin(Cin),
    .Busy(Busy), .Done(Done), .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  serial_addsub #(.WIDTH(1), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .Start(s_start), .Sub(s_sub), .A(s_a), .B(s_b),
    .Cin(s_cin), .Busy(s_busy), .Done(s_done), .Sum(s_sum), .Cout(s_cout),
    .Ovf(s_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch an operation; lat = cycle number of the first Done (Start edge is
  // the end of cycle 0). Returns at the negedge of the Done cycle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, output int lat);
    @(negedge clk); A = a; B = b; Cin = cin; Sub = sub; Start = 1'b1;
    @(negedge clk); Start = 1'b0;
    lat = 1;
    while (!Done && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic run1(input logic a, input logic b, input logic cin, output int lat);
    @(negedge clk); s_a = a; s_b = b; s_cin = cin; s_sub = 1'b0; s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    lat = 1;
    while (!s_done && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic check_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] es,
                          input logic ec, input logic eo);
    int lat;
    run_op(a, b, cin, sub, lat);
    chk({tag, "_lat"}, lat, 5);
    chk({tag, "_sum"}, Sum, es);
    chk({tag, "_cout"}, Cout, ec);
    chk({tag, "_ovf"}, Ovf, eo);
    @(negedge clk);
    chk({tag, "_done_low"}, Done, 0);
    chk({tag, "_idle"}, Busy, 0);
  endtask

  initial begin
    int lat, ndone, c;
    int dcyc [3];

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_sum", Sum, 0);
    chk("rst_cout", Cout, 0);
    chk("rst_ovf", Ovf, 0);
    rst = 1'b0;

    // load nonzero outputs, then reset asynchronously mid-cycle
    check_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_sum", Sum, 0);
    chk("arst_cout", Cout, 0);
    chk("arst_ovf", Ovf, 0);
    chk("arst_busy", Busy, 0);
    @(negedge clk); @(negedge clk);
    chk("arst_hold_sum", Sum, 0);
    chk("arst_hold_done", Done, 0);
    rst = 1'b0;

    check_op("add", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    check_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    check_op("sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    check_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // busy: inputs and Start during RUN ignored; Sum holds 0x8000 until done
    @(negedge clk); A = 16'h0001; B = 16'h0001; Cin = 0; Sub = 0; Start = 1'b1;
    @(negedge clk); Start = 1'b0;                     // cycle 1
    @(negedge clk); A = 16'hAAAA; Start = 1'b1;       // cycle 2
    chk("busy_c2_sum", Sum, 16'h8000);
    chk("busy_c2_busy", Busy, 1);
    @(negedge clk); Start = 1'b0;                     // cycle 3
    chk("busy_c3_sum", Sum, 16'h8000);
    @(negedge clk);                                   // cycle 4
    chk("busy_c4_sum", Sum, 16'h8000);
    chk("busy_c4_done", Done, 0);
    @(negedge clk);                                   // cycle 5
    chk("busy_c5_done", Done, 1);
    chk("busy_c5_sum", Sum, 16'h0002);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (Done) ndone++; end
    chk("busy_single_done", ndone, 0);

    // Start held high: Done in cycles 5, 11, 17
    @(negedge clk); A = 16'h0001; B = 16'h0002; Cin = 0; Sub = 0; Start = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (Done) begin
        if (ndone < 3) dcyc[ndone] = n;
        ndone++;
        chk("held_sum", Sum, 16'h0003);
      end
    end
    Start = 1'b0;                                     // still in cycle 18
    chk("held_count", ndone, 3);
    chk("held_d0", dcyc[0], 5);
    chk("held_d1", dcyc[1], 11);
    chk("held_d2", dcyc[2], 17);

    // abort in cycle 2
    @(negedge clk); A = 16'h1111; B = 16'h0001; Start = 1'b1;
    @(negedge clk); Start = 1'b0;                     // cycle 1
    @(negedge clk); rst = 1'b1;                       // cycle 2
    #1;
    chk("abort_sum", Sum, 0);
    chk("abort_busy", Busy, 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (Done) ndone++; end
    chk("abort_no_done", ndone, 0);
    chk("abort_sum_hold", Sum, 0);
    check_op("post_abort", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // WIDTH = CHUNK = 1: full-adder truth table
    for (int v = 0; v < 8; v++) begin
      logic a1, b1, c1;
      a1 = v[2]; b1 = v[1]; c1 = v[0];
      c = int'(a1) + int'(b1) + int'(c1);
      run1(a1, b1, c1, lat);
      chk("fa_lat", lat, 2);
      chk("fa_sum", s_sum, c % 2);
      chk("fa_cout", s_cout, c / 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
